booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
Sequential controller for the radix-4 Booth multiply step datapath. It takes a signed WIDTH-bit multiplicand and multiplier, then iterates WIDTH/2 Booth steps, one per clock: select the Booth code, add/subtract 0/A/2A into the upper accumulator half, and arithmetic-shift right by 2. It then presents the signed 2*WIDTH-bit product with a start/done handshake. It sits between the operand/command front end and the multiply datapath, and owns the accumulator register, the step counter and the FSM.

Parameters:
WIDTH, 64, operand width in bits; must be even and >= 4; product is 2*WIDTH bits
CNT_W, 8, step counter width; must satisfy 2^CNT_W > WIDTH/2

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op_start  input  1  start pulse; sampled only in IDLE or DONE
op_clear  input  1  synchronous abort/clear, any state
multiplicand  input  WIDTH  signed A; latched on accepted op_start
multiplier  input  WIDTH  signed B; latched on accepted op_start
op_busy  output  1  high while in EXEC
op_done  output  1  high while in DONE
result  output  2*WIDTH  signed product A*B; valid while op_done=1
cnt  output  CNT_W  current step index (0..WIDTH/2-1 in EXEC)

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset).
- Reset or op_clear, sampled high at a clock edge: state=IDLE, acc=0, prev=0, cnt=0, a_reg=0. Next cycle op_busy=0, op_done=0, result=0, cnt=0. op_clear beats op_start in the same cycle. Reset mid-EXEC abandons the operation with no done pulse.
- States:
  - IDLE: on op_start, go to EXEC.
  - EXEC: after step WIDTH/2-1 completes, go to DONE.
  - DONE: on op_start, go to EXEC (new operation); on op_clear, go to IDLE; otherwise hold.
- Load on accepted op_start:
  - a_reg = multiplicand.
  - acc[2*WIDTH-1:WIDTH] = 0 (upper half held internally as WIDTH+2 bits, sign-extended, to avoid overflow on ±2A).
  - acc[WIDTH-1:0] = multiplier, prev = 0, cnt = 0.
- Each EXEC cycle:
  - x = {acc[1], acc[0], prev}.
  - Booth select: 000/111 -> +0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - A and 2A are sign-extended to WIDTH+2 bits; subtraction is two's complement (~v + 1).
  - upper = upper + sel; prev = acc[1].
  - The whole {upper, lower} is arithmetic-shifted right by 2, replicating the sign bit; cnt = cnt+1.
- Latency: op_start accepted at edge 0. EXEC occupies edges 1..WIDTH/2 (32 for default). op_done rises at edge WIDTH/2 (32 for default), the same edge on which the final step is written.
- result = low 2*WIDTH bits of the final accumulator. It is held stable in DONE until op_clear, reset, or a new op_start.
- result is 0 in IDLE. During EXEC, result shows the in-progress accumulator; it is not valid.
- op_start during EXEC: ignored, with no effect on state, operands or counter.
- op_start in DONE: reloads immediately. op_done drops and op_busy rises on the next edge.
- Operand inputs are don't-care except in the op_start accept cycle.
- op_busy and op_done are never high simultaneously.
- cnt wraps only via reload; it never exceeds WIDTH/2.

Test Plan:
1. Reset, then op_start with A=7, B=-3 (64'hFFFF_FFFF_FFFF_FFFD) -> op_busy for 32 cycles, op_done at cycle 32, result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB.
2. A=B=64'h8000_0000_0000_0000 (most-negative squared) -> result=128'h4000_0000_0000_0000_0000_0000_0000_0000; also A=64'h8000..0, B=1 -> result=128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000 (checks the 2A overflow guard).
3. A=0x1234_5678_9ABC_DEF0, B=0 -> result=0; then A=-1, B=-1 -> result=1. Also run 1000 random signed pairs against a reference product.
4. Pulse op_start again at EXEC cycle 10 with different operands -> ignored; result equals the first operation's product at cycle 32.
5. In DONE, issue op_start with new operands -> op_done falls the next cycle, and the new product appears 32 cycles later. Back-to-back operations complete correctly.
6. Assert reset at EXEC cycle 15 -> next cycle all outputs are 0 and state is IDLE, with no op_done. Repeat with op_clear, and with op_clear and op_start in the same cycle -> clear wins, stays IDLE.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: latches signed operands on op_start, retires
// one Booth digit per clock for WIDTH/2 clocks, then holds the 2*WIDTH-bit product.
module booth_mul_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 op_busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result,
    output logic [CNT_W-1:0]     cnt
);

    // Upper accumulator half carries two guard bits so that +/-2A never overflows.
    localparam int UW = WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [UW-1:0]    upper_reg;
    logic [WIDTH-1:0] lower_reg;
    logic [WIDTH-1:0] a_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [2:0]       booth_code;
    logic [UW-1:0]    a_ext;
    logic [UW-1:0]    a2_ext;
    logic [UW-1:0]    addend;
    logic [UW-1:0]    upper_sum;
    logic [UW-1:0]    upper_next;
    logic [WIDTH-1:0] lower_next;

    assign a_ext      = {{2{a_reg[WIDTH-1]}}, a_reg};
    assign a2_ext     = {a_reg[WIDTH-1], a_reg, 1'b0};
    assign booth_code = {lower_reg[1:0], prev_reg};

    always_comb begin
        addend = '0;
        case (booth_code)
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = a2_ext;
            3'b100:         addend = ~a2_ext + UW'(1);
            3'b101, 3'b110: addend = ~a_ext + UW'(1);
            default:        addend = '0;
        endcase
    end

    assign upper_sum  = upper_reg + addend;
    assign upper_next = {{2{upper_sum[UW-1]}}, upper_sum[UW-1:2]};

    // The two bits shifted out of the upper half enter the top of the lower half.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 2; gi++) begin : g_lower_shift
            assign lower_next[gi] = lower_reg[gi+2];
        end
    endgenerate
    assign lower_next[WIDTH-1:WIDTH-2] = upper_sum[1:0];

    always_ff @(posedge clk) begin
        if (reset || op_clear) begin
            state_reg <= IDLE;
            upper_reg <= '0;
            lower_reg <= '0;
            a_reg     <= '0;
            prev_reg  <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (op_start) begin
                        state_reg <= EXEC;
                        a_reg     <= multiplicand;
                        upper_reg <= '0;
                        lower_reg <= multiplier;
                        prev_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                EXEC: begin
                    upper_reg <= upper_next;
                    lower_reg <= lower_next;
                    prev_reg  <= lower_reg[1];
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_STEP) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator is zero whenever the FSM sits in IDLE, so result reads 0 there.
    assign result  = {upper_reg[WIDTH-1:0], lower_reg};
    assign cnt     = cnt_reg;
    assign op_busy = busy_reg;
    assign op_done = done_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vector table, multi-cycle corner
// sequences and random operand pairs compared against a plain signed product.
module tb_booth_mul_seq;

    localparam int WIDTH = 64;
    localparam int CNT_W = 8;
    localparam int STEPS = WIDTH / 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               op_start;
    logic               op_clear;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               op_busy;
    logic               op_done;
    logic [2*WIDTH-1:0] result;
    logic [CNT_W-1:0]   cnt;

    int tests  = 0;
    int failed = 0;

    booth_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_busy      (op_busy),
        .op_done      (op_done),
        .result       (result),
        .cnt          (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [127:0]     exp;
    } vec_t;

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ea;
        logic signed [127:0] eb;
        ea = {{64{a[63]}}, a};
        eb = {{64{b[63]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] rand_operand();
        int pick;
        pick = $urandom_range(0, 9);
        case (pick)
            0: return 64'h0;
            1: return 64'h1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns at the falling edge after the accepting rising edge; operands become garbage.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        op_start     = 1'b0;
        multiplicand = {$urandom(), $urandom()};
        multiplier   = {$urandom(), $urandom()};
    endtask

    // lat counts rising edges since the accepting edge; bounded so a stuck DUT still ends.
    task automatic wait_done(input int start_lat, output int lat);
        logic bad;
        bad = 1'b0;
        lat = start_lat;
        while (op_done !== 1'b1 && lat < 200) begin
            if (op_busy !== 1'b1 || cnt !== CNT_W'(lat)) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("busy_and_cnt_during_exec", {127'b0, bad}, 128'd0);
        check("busy_low_in_done", {127'b0, op_busy}, 128'd0);
        check("cnt_in_done", {120'b0, cnt}, 128'(STEPS));
    endtask

    task automatic run_and_check(input string name, input logic [63:0] a, input logic [63:0] b,
                                 input logic [127:0] exp);
        int lat;
        start_op(a, b);
        wait_done(0, lat);
        check({name, "_latency"}, 128'(lat), 128'(STEPS));
        check({name, "_result"}, result, exp);
        $display("[TB] %s a=%h b=%h result=%h lat=%0d", name, a, b, result, lat);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, {127'b0, op_busy}, 128'd0);
        check({name, "_done"}, {127'b0, op_done}, 128'd0);
        check({name, "_result"}, result, 128'd0);
        check({name, "_cnt"}, {120'b0, cnt}, 128'd0);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (op_done !== 1'b0 || op_busy !== 1'b0) seen = 1'b1;
        end
        check({name, "_stays_idle"}, {127'b0, seen}, 128'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   lat;
        logic [63:0] ra;
        logic [63:0] rb;

        vecs[0] = '{"a7_bm3",     64'd7,                   64'hFFFF_FFFF_FFFF_FFFD,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{"min_sq",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[2] = '{"min_x1",     64'h8000_0000_0000_0000, 64'd1,
                    128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
        vecs[3] = '{"x_zero",     64'h1234_5678_9ABC_DEF0, 64'd0, 128'd0};
        vecs[4] = '{"m1_m1",      64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};

        reset        = 1'b1;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle("reset");

        foreach (vecs[i]) run_and_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);

        // op_start during EXEC is ignored
        start_op(64'd123456789, 64'hFFFF_FFFF_FFFF_0001);
        repeat (10) @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 64'd99;
        multiplier   = 64'd77;
        @(negedge clk);
        op_start = 1'b0;
        wait_done(11, lat);
        check("ignored_start_latency", 128'(lat), 128'(STEPS));
        check("ignored_start_result", result, ref_mul(64'd123456789, 64'hFFFF_FFFF_FFFF_0001));
        $display("[TB] ignored_start result=%h lat=%0d", result, lat);

        // Restart from DONE: done drops, busy rises on the accepting edge
        start_op(64'hFFFF_FFFF_FFFF_FF00, 64'd3);
        check("restart_done_drop", {127'b0, op_done}, 128'd0);
        check("restart_busy_rise", {127'b0, op_busy}, 128'd1);
        wait_done(0, lat);
        check("restart_latency", 128'(lat), 128'(STEPS));
        check("restart_result", result, ref_mul(64'hFFFF_FFFF_FFFF_FF00, 64'd3));
        $display("[TB] restart result=%h lat=%0d", result, lat);

        // Reset in the middle of EXEC abandons the operation
        start_op(64'd5, 64'd6);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("mid_reset");
        watch_no_done("mid_reset", 40);
        $display("[TB] mid_exec reset done");

        // op_clear in the middle of EXEC
        start_op(64'd11, 64'd13);
        repeat (14) @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        check_idle("mid_clear");
        watch_no_done("mid_clear", 40);
        $display("[TB] mid_exec clear done");

        // op_clear and op_start together in DONE: clear wins
        run_and_check("pre_clear", 64'd21, 64'd2, 128'd42);
        @(negedge clk);
        op_clear     = 1'b1;
        op_start     = 1'b1;
        multiplicand = 64'd3;
        multiplier   = 64'd4;
        @(negedge clk);
        op_clear = 1'b0;
        op_start = 1'b0;
        check_idle("clear_and_start");
        watch_no_done("clear_and_start", 5);
        $display("[TB] clear_and_start done");

        for (int i = 0; i < 1000; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            run_and_check($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
